uart_rx: RTL

- 8N1 UART receiver with 16x oversampling. It consumes the one-clk_in-cycle rxclk tick from the baud rate generator and deserialises the rx line into bytes.
- Each byte is presented on a valid/ack holding register with frame-error and overrun status.
- Sits between the pad-side rx input and the host-side byte consumer; it is the receive counterpart of the generator's rxclk output.

---
 rtl/uart_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with OVS-times oversampling, driven by the baud generator's rxclk tick.
// Received bytes are held on a valid/ack register together with frame-error and overrun status.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int MID       = OVS / 2 - 1
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 rxclk,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t               state_reg;
    logic [TW-1:0]        tick_cnt_reg;
    logic [BW-1:0]        bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic                 done_reg;
    logic                 stop_reg;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // done_reg/stop_reg carry the stop-sample result into the next cycle, where
    // the holding register decides between accepting the byte and flagging overrun.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            done_reg     <= 1'b0;
            stop_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (rxclk) begin
                case (state_reg)
                    IDLE: begin
                        if (!rx_s_reg) begin
                            state_reg    <= START;
                            tick_cnt_reg <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt_reg == TW'(MID)) begin
                            tick_cnt_reg <= '0;
                            bit_idx_reg  <= '0;
                            state_reg    <= rx_s_reg ? IDLE : DATA;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt_reg == TW'(OVS - 1)) begin
                            tick_cnt_reg           <= '0;
                            shift_reg[bit_idx_reg] <= rx_s_reg;
                            if (bit_idx_reg == BW'(DATA_BITS - 1))
                                state_reg <= STOP;
                            else
                                bit_idx_reg <= bit_idx_reg + 1'b1;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt_reg == TW'(OVS - 1)) begin
                            tick_cnt_reg <= '0;
                            done_reg     <= 1'b1;
                            stop_reg     <= rx_s_reg;
                            state_reg    <= rx_s_reg ? IDLE : BREAK;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    BREAK: begin
                        // Wait for the line to return high so a held-low line cannot retrigger.
                        if (rx_s_reg)
                            state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (done_reg) begin
            if (!rx_valid || rx_ack) begin
                rx_data   <= shift_reg;
                frame_err <= ~stop_reg;
                rx_valid  <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end
    end

    assign busy = (state_reg != IDLE);

endmodule
